// File: rtl/axis_window_pkg.sv
// Shared types and geometry helpers for the axis_window crop block.
package axis_window_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF,
      ACTIVE,
      DONE
   } win_state_t;

   // Length of [off, off+len) clipped to [0, total).
   function automatic logic [31:0] clip_len(
      input logic [31:0] off,
      input logic [31:0] len,
      input logic [31:0] total
   );
      logic [31:0] room;
      logic [31:0] res;
      room = total - off;
      if (off >= total)
         res = '0;
      else if (len < room)
         res = len;
      else
         res = room;
      return res;
   endfunction

endpackage

// File: rtl/axis_window_reg_slice.sv
// Registered valid/data/user/last output stage with ready pass-through.
module axis_reg_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_user,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_user,
   output logic         out_last,
   input  logic         out_ready
);

   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_user  <= 1'b0;
         out_last  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_user  <= 1'b0;
         out_last  <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_user  <= in_user;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_window.sv
// Crops a rectangular window out of an AXI4-Stream video frame.
module axis_window
   import axis_window_pkg::*;
#(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_RESO_WIDTH  = 10
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     fsync,
   input  logic [C_RESO_WIDTH-1:0]  s_width,
   input  logic [C_RESO_WIDTH-1:0]  s_height,
   input  logic [C_RESO_WIDTH-1:0]  win_left,
   input  logic [C_RESO_WIDTH-1:0]  win_top,
   input  logic [C_RESO_WIDTH-1:0]  win_width,
   input  logic [C_RESO_WIDTH-1:0]  win_height,
   output logic [C_RESO_WIDTH-1:0]  m_width,
   output logic [C_RESO_WIDTH-1:0]  m_height,
   input  logic                     s_axis_tvalid,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic                     m_axis_tvalid,
   output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready
);

   localparam int RW = C_RESO_WIDTH;
   localparam int CW = C_RESO_WIDTH + 1;

   logic [RW-1:0] cfg_sw, cfg_sh, cfg_l, cfg_t, cfg_w, cfg_h;
   logic          boot;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_sw   <= '0;
         cfg_sh   <= '0;
         cfg_l    <= '0;
         cfg_t    <= '0;
         cfg_w    <= '0;
         cfg_h    <= '0;
         boot     <= 1'b1;
         m_width  <= '0;
         m_height <= '0;
      end else begin
         if (boot || fsync) begin
            cfg_sw <= s_width;
            cfg_sh <= s_height;
            cfg_l  <= win_left;
            cfg_t  <= win_top;
            cfg_w  <= win_width;
            cfg_h  <= win_height;
         end
         boot     <= 1'b0;
         m_width  <= RW'(clip_len(32'(cfg_l), 32'(cfg_w), 32'(cfg_sw)));
         m_height <= RW'(clip_len(32'(cfg_t), 32'(cfg_h), 32'(cfg_sh)));
      end
   end

   win_state_t st;
   logic [CW-1:0] col, row;
   logic          first;

   logic          acc, sof, live, in_win, emit, edge_last;
   logic [CW-1:0] c, r, row_nx, left_lim, top_lim;

   // A tuser pixel always restarts the frame at (0,0), whatever the state.
   assign acc       = s_axis_tvalid & s_axis_tready;
   assign sof       = s_axis_tuser;
   assign live      = sof | (st == ACTIVE);
   assign c         = sof ? '0 : col;
   assign r         = sof ? '0 : row;
   assign row_nx    = r + 1'b1;
   assign left_lim  = CW'(cfg_l) + CW'(m_width);
   assign top_lim   = CW'(cfg_t) + CW'(m_height);
   assign edge_last = (c == left_lim - 1'b1);
   assign in_win    = live
                    && (r >= CW'(cfg_t)) && (r < top_lim)
                    && (c >= CW'(cfg_l)) && (c < left_lim);
   assign emit      = acc & ~fsync & in_win;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st    <= WAIT_SOF;
         col   <= '0;
         row   <= '0;
         first <= 1'b0;
      end else if (fsync) begin
         st    <= WAIT_SOF;
         col   <= '0;
         row   <= '0;
         first <= 1'b0;
      end else if (acc && live) begin
         first <= (sof | first) & ~in_win;
         if (s_axis_tlast) begin
            col <= '0;
            row <= row_nx;
            if (row_nx >= CW'(cfg_sh) || row_nx >= top_lim)
               st <= DONE;
            else
               st <= ACTIVE;
         end else begin
            col <= (c < CW'(cfg_sw)) ? c + 1'b1 : c;
            row <= r;
            st  <= ACTIVE;
         end
      end
   end

   axis_reg_slice #(
      .W (C_PIXEL_WIDTH)
   ) u_slice (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (fsync),
      .in_valid  (emit),
      .in_data   (s_axis_tdata),
      .in_user   (sof | first),
      .in_last   (edge_last | s_axis_tlast),
      .in_ready  (s_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (m_axis_tdata),
      .out_user  (m_axis_tuser),
      .out_last  (m_axis_tlast),
      .out_ready (m_axis_tready)
   );

endmodule

// File: tb/tb_axis_window.sv
// Directed bench for axis_window: crop geometry, clipping, stalls, fsync, reset.
module tb_axis_window;

   localparam int PW = 8;
   localparam int RW = 10;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          fsync = 1'b0;
   logic [RW-1:0] s_width, s_height, win_left, win_top, win_width, win_height;
   logic [RW-1:0] m_width, m_height;
   logic          s_tvalid = 1'b0;
   logic [PW-1:0] s_tdata = '0;
   logic          s_tuser = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic          m_tvalid;
   logic [PW-1:0] m_tdata;
   logic          m_tuser, m_tlast;
   logic          m_tready = 1'b1;

   int   checks = 0;
   int   failures = 0;
   int   in_cnt = 0;
   int   hold_err = 0;
   bit   hold_chk = 0;
   bit   rnd_en = 0;
   logic prev_v = 1'b0;
   logic [9:0] prev_b = '0;
   logic [9:0] out_q[$];
   logic [9:0] exp_q[$];

   axis_window dut (
      .clk           (clk),
      .resetn        (resetn),
      .fsync         (fsync),
      .s_width       (s_width),
      .s_height      (s_height),
      .win_left      (win_left),
      .win_top       (win_top),
      .win_width     (win_width),
      .win_height    (win_height),
      .m_width       (m_width),
      .m_height      (m_height),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tdata  (s_tdata),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tuser  (m_tuser),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rnd_en) m_tready = 1'($urandom_range(0, 1));

   always @(posedge clk) begin
      if (resetn) begin
         if (s_tvalid && s_tready) in_cnt++;
         if (m_tvalid && m_tready)
            out_q.push_back({m_tuser, m_tlast, m_tdata});
         if (hold_chk && prev_v
             && !(m_tvalid && {m_tuser, m_tlast, m_tdata} == prev_b))
            hold_err++;
         prev_v = m_tvalid && !m_tready;
         prev_b = {m_tuser, m_tlast, m_tdata};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic u, input logic l);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      #1;
      while (!s_tready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!s_tready) chk("push_timeout", 32'(s_tready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int w, input int h,
                             input int srow, input int slen);
      for (int r = 0; r < h; r++) begin
         int len = (r == srow) ? slen : w;
         for (int c = 0; c < len; c++)
            push(8'(r * 16 + c), (r == 0 && c == 0), (c == len - 1));
      end
   endtask

   task automatic expect_win(input int l, input int ew, input int t,
                             input int eh, input int fw, input int fh,
                             input int srow, input int slen);
      bit f = 1;
      exp_q.delete();
      for (int r = t; r < t + eh && r < fh; r++) begin
         int len = (r == srow) ? slen : fw;
         for (int c = l; c < l + ew && c < len; c++) begin
            exp_q.push_back({f, (c == l + ew - 1) || (c == len - 1),
                             8'(r * 16 + c)});
            f = 0;
         end
      end
   endtask

   task automatic drain(input int n);
      int k = 0;
      while (out_q.size() < n && k < 1000) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic compare(input string tag);
      int n;
      chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_beat%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
   endtask

   task automatic set_cfg(input int l, input int t, input int w, input int h);
      win_left   = RW'(l);
      win_top    = RW'(t);
      win_width  = RW'(w);
      win_height = RW'(h);
      @(negedge clk);
      fsync = 1'b1;
      @(negedge clk);
      fsync = 1'b0;
      repeat (2) @(negedge clk);
      out_q.delete();
      in_cnt = 0;
   endtask

   initial begin
      s_width    = 10'd8;
      s_height   = 10'd4;
      win_left   = 10'd2;
      win_top    = 10'd1;
      win_width  = 10'd3;
      win_height = 10'd2;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 32'(m_tvalid), 0);
      chk("rst_tuser", 32'(m_tuser), 0);
      chk("rst_tlast", 32'(m_tlast), 0);
      chk("rst_tdata", 32'(m_tdata), 0);
      chk("rst_m_width", 32'(m_width), 0);
      chk("rst_m_height", 32'(m_height), 0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      chk("boot_m_width", 32'(m_width), 3);
      chk("boot_m_height", 32'(m_height), 2);

      // Basic 3x2 window at (2,1).
      out_q.delete();
      in_cnt = 0;
      send_frame(8, 4, -1, 0);
      drain(6);
      expect_win(2, 3, 1, 2, 8, 4, -1, 0);
      compare("basic");
      chk("basic_in_cnt", 32'(in_cnt), 32);

      // Right edge clipping: left=6 w=5 -> 2 columns.
      set_cfg(6, 1, 5, 2);
      chk("clipw_m_width", 32'(m_width), 2);
      send_frame(8, 4, -1, 0);
      drain(4);
      expect_win(6, 2, 1, 2, 8, 4, -1, 0);
      compare("clipw");

      // Window below the frame: nothing out, all consumed.
      set_cfg(6, 4, 5, 2);
      chk("empty_m_height", 32'(m_height), 0);
      send_frame(8, 4, -1, 0);
      drain(0);
      chk("empty_out", 32'(out_q.size()), 0);
      chk("empty_in_cnt", 32'(in_cnt), 32);

      // Full window with random backpressure.
      set_cfg(0, 0, 8, 4);
      rnd_en = 1;
      hold_chk = 1;
      send_frame(8, 4, -1, 0);
      drain(32);
      rnd_en = 0;
      hold_chk = 0;
      m_tready = 1'b1;
      repeat (4) @(negedge clk);
      expect_win(0, 8, 0, 4, 8, 4, -1, 0);
      compare("stall");
      chk("stall_hold", 32'(hold_err), 0);

      // Row 2 truncated to 3 pixels.
      set_cfg(2, 0, 3, 4);
      send_frame(8, 4, 2, 3);
      drain(10);
      expect_win(2, 3, 0, 4, 8, 4, 2, 3);
      compare("short");

      // fsync while the slice holds a stalled beat.
      set_cfg(0, 0, 8, 4);
      m_tready = 1'b0;
      push(8'h00, 1'b1, 1'b0);
      chk("fs_pre_tvalid", 32'(m_tvalid), 1);
      win_width  = 10'd2;
      win_height = 10'd1;
      fsync = 1'b1;
      @(posedge clk);
      #1;
      chk("fs_tvalid", 32'(m_tvalid), 0);
      @(negedge clk);
      fsync = 1'b0;
      m_tready = 1'b1;
      out_q.delete();
      push(8'h11, 1'b0, 1'b0);
      push(8'h12, 1'b0, 1'b0);
      push(8'h13, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("fs_drop", 32'(out_q.size()), 0);
      chk("fs_m_width", 32'(m_width), 2);
      chk("fs_m_height", 32'(m_height), 1);
      send_frame(8, 4, -1, 0);
      drain(2);
      expect_win(0, 2, 0, 1, 8, 4, -1, 0);
      compare("fsnew");

      // Asynchronous reset in the middle of a line.
      set_cfg(0, 0, 8, 4);
      for (int c = 0; c < 5; c++)
         push(8'(c), (c == 0), 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 8'h05;
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_tvalid", 32'(m_tvalid), 0);
      chk("arst_tdata", 32'(m_tdata), 0);
      chk("arst_tlast", 32'(m_tlast), 0);
      chk("arst_m_width", 32'(m_width), 0);
      s_tvalid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      out_q.delete();
      for (int c = 5; c < 8; c++)
         push(8'(c), 1'b0, (c == 7));
      for (int c = 0; c < 8; c++)
         push(8'(16 + c), 1'b0, (c == 7));
      repeat (4) @(negedge clk);
      chk("arst_partial", 32'(out_q.size()), 0);
      send_frame(8, 4, -1, 0);
      drain(32);
      expect_win(0, 8, 0, 4, 8, 4, -1, 0);
      compare("arst_frame");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
